// File: rtl/dff_pipe.sv
// Parametrised valid/ready register pipeline: DEPTH stages of WIDTH bits, bubbles collapse forward.
// Define DFF_PIPE_RESET_DATA_EN to also clear the data registers on reset.
module dff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0]            v, adv, vin;
  logic [DEPTH-1:0][WIDTH-1:0] d, din;
  logic                        acc, xfer;

  // A stage may advance if it is empty or everything downstream of it moves.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = !v[DEPTH-1] | out_ready;
    for (int i = DEPTH-2; i >= 0; i--) adv[i] = !v[i] | adv[i+1];
  end

  assign in_ready  = adv[0] & !flush;
  assign acc       = in_valid & in_ready;
  assign xfer      = v[DEPTH-1] & out_ready;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  always_comb begin
    vin    = '0;
    din    = '0;
    vin[0] = acc;
    din[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vin[i] = v[i-1];
      din[i] = d[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      v     <= '0;
      count <= '0;
    end else if (flush) begin
      v     <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (adv[i]) v[i] <= vin[i];
      count <= count + CW'(acc) - CW'(xfer);
    end
  end

  // Data only toggles when a valid word moves in; bubbles leave d untouched.
`ifdef DFF_PIPE_RESET_DATA_EN
  always_ff @(posedge clk) begin
    if (!rstn) d <= '0;
    else
      for (int i = 0; i < DEPTH; i++)
        if (adv[i] && vin[i]) d[i] <= din[i];
  end
`else
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (adv[i] && vin[i]) d[i] <= din[i];
  end
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Scoreboard bench for dff_pipe: DEPTH=4 instance for flow control, DEPTH=1 instance for throughput.
module tb_dff_pipe;
  logic       clk = 1'b0;
  logic       rstn, flush, in_valid, out_ready;
  logic       in_ready, out_valid;
  logic [7:0] in_data, out_data;
  logic [2:0] count;

  logic       in_valid1, out_ready1, in_ready1, out_valid1;
  logic [7:0] in_data1, out_data1;
  logic [0:0] count1;

  int n_chk = 0, n_fail = 0;
  logic [7:0] q[$], q1[$];

  always #5 clk = ~clk;

  dff_pipe #(.WIDTH(8), .DEPTH(4)) u_dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count));

  dff_pipe #(.WIDTH(8), .DEPTH(1)) u_one (
    .clk(clk), .rstn(rstn), .flush(1'b0), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .count(count1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Inputs change just after posedge, so the negedge sees what the next edge will sample.
  always @(negedge clk) begin
    if (rstn) begin
      chk("count_vs_model", 32'(count), 32'(q.size()));
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        else chk("out_data", 32'(out_data), 32'(q.pop_front()));
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(in_data);
      if (out_valid1 && out_ready1) begin
        if (q1.size() == 0) chk("unexpected_out1", 32'(out_data1), 32'hFFFF_FFFF);
        else chk("out_data1", 32'(out_data1), 32'(q1.pop_front()));
      end
      if (in_valid1 && in_ready1) q1.push_back(in_data1);
    end else begin
      q.delete();
      q1.delete();
    end
  end

  task automatic fill(input logic [7:0] base);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = base + 8'(k);
      step();
    end
    in_valid = 1'b0;
    chk("fill_count", 32'(count), 32'd4);
  endtask

  initial begin
    logic [7:0] nxt;
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; in_data1 = '0;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
`ifdef DFF_PIPE_RESET_DATA_EN
    chk("rst_out_data", 32'(out_data), 32'd0);
`endif
    rstn = 1'b1;

    // Stream 0x01..0x08 with no stall
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(i + 1);
      step();
      chk("stream_out_valid", 32'(out_valid), (i >= 3) ? 32'd1 : 32'd0);
      chk("stream_count", 32'(count), (i >= 3) ? 32'd4 : 32'(i + 1));
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("stream_drained", 32'(count), 32'd0);

    // Full stall: 6 offered, 4 accepted
    out_ready = 1'b0;
    in_valid  = 1'b1;
    nxt = 8'h01;
    for (int c = 0; c < 6; c++) begin
      in_data = nxt;
      #1;
      chk("stall_in_ready", 32'(in_ready), (c < 4) ? 32'd1 : 32'd0);
      if (in_ready) nxt++;
      step();
    end
    chk("stall_count", 32'(count), 32'd4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_count", 32'(count), 32'(3 - i));
    end

    // Bubble collapse: A0, gap, A1 under stall
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hA0; step();
    in_valid = 1'b0; step();
    in_valid = 1'b1; in_data = 8'hA1; step();
    in_valid = 1'b0; step(); step(); step();
    chk("bubble_count", 32'(count), 32'd2);
    chk("bubble_in_ready", 32'(in_ready), 32'd1);
    chk("bubble_head", 32'(out_data), 32'hA0);
    chk("bubble_v2", 32'(u_dut.v), 32'b1100);
    chk("bubble_d2", 32'(u_dut.d[2]), 32'hA1);
    out_ready = 1'b1;
    step(); step();
    chk("bubble_drained", 32'(count), 32'd0);

    // Flush with concurrent output handshake
    fill(8'h31);
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_head", 32'(out_data), 32'h31);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_count", 32'(count), 32'd0);
    step();
    chk("flush_stays_empty", 32'(out_valid), 32'd0);

    // Reset mid-stall
    fill(8'h41);
    rstn = 1'b0; step(); rstn = 1'b1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
`ifdef DFF_PIPE_RESET_DATA_EN
    chk("midrst_out_data", 32'(out_data), 32'd0);
`endif

    // Random traffic with occasional flush; scoreboard does the checking
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("random_drained", 32'(count), 32'd0);

    // DEPTH=1: one word per cycle, 1-cycle latency
    in_valid1 = 1'b1; out_ready1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data1 = 8'h10 + 8'(i);
      #1;
      chk("d1_in_ready", 32'(in_ready1), 32'd1);
      step();
      chk("d1_out_valid", 32'(out_valid1), 32'd1);
      chk("d1_out_data", 32'(out_data1), 32'h10 + 32'(i));
    end
    in_valid1 = 1'b0;
    step();
    chk("d1_empty", 32'(out_valid1), 32'd0);
    chk("d1_queue_empty", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
